kcore_formal_mem: RTL and testbench
===================================

# kcore_formal_mem

Parametrised memory model for the kcore formal and simulation harnesses. It replaces the fixed 4 KB always-ready array with independent instruction and data ports. Each port has a configurable response latency and an optional external stall input. Out-of-range accesses are bounded and flagged. It sits between kcore's imem/dmem valid/ready interfaces and the RVFI harness.

## Interface
Parameters:
- MEM_WORDS, 1024, depth in 32-bit words; power of two, ≥ 4
- BASE_ADDR, 32'h0000_0000, byte address of word 0; aligned to 4*MEM_WORDS
- IMEM_LATENCY, 0, wait cycles from imem request to imem_ready (0–15)
- DMEM_LATENCY, 0, wait cycles from dmem request to dmem_ready (0–15)
- ENABLE_STALL, 0, 1 = the *_stall inputs add wait cycles; 0 = the stalls are ignored

Ports (one clock; reset is synchronous and active-high):
- clock  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-high reset
- imem_valid  in  1  instruction fetch request, held until ready
- imem_addr  in  32  fetch byte address
- imem_rdata  out  32  fetch data, valid while imem_ready
- imem_ready  out  1  fetch response
- imem_stall  in  1  extra fetch wait (formal: unconstrained)
- dmem_valid  in  1  data request, held until ready
- dmem_write  in  1  1 = store, 0 = load
- dmem_addr  in  32  data byte address
- dmem_wdata  in  32  store data
- dmem_wstrb  in  4  store byte enables
- dmem_rdata  out  32  load data, valid while dmem_ready
- dmem_ready  out  1  data response
- dmem_stall  in  1  extra data wait
- imem_err  out  1  fetch out of range; pulses with imem_ready
- dmem_err  out  1  data access out of range; pulses with dmem_ready

## Operation
- Word index = (addr − BASE_ADDR) >> 2, width $clog2(MEM_WORDS). addr[1:0] is ignored.
- In range: BASE_ADDR ≤ addr < BASE_ADDR + 4*MEM_WORDS.
- Out of range:
  - rdata = 0
  - store dropped
  - the port's err is asserted in the same cycle as its ready
- Memory contents are never reset. In formal they are unconstrained; in sim they are X unless loaded by $readmemh.
- Per-port FSM, states IDLE and WAIT, 4-bit counter cnt.
  - IDLE, valid=0: stay.
  - IDLE, valid=1, LATENCY=0, stall inactive: ready asserted combinationally this cycle; stay IDLE.
  - IDLE, valid=1, otherwise: go to WAIT with cnt=0.
  - WAIT: cnt increments each cycle the stall is inactive; it holds while the stall is active.
  - WAIT: ready=1 when cnt==LATENCY−1 and the stall is inactive. The FSM then returns to IDLE on the next edge.
  - WAIT, valid drops (protocol violation): return to IDLE, clear cnt, no ready, no write.
- Stall is treated as inactive when ENABLE_STALL=0.
- rdata is read combinationally from the array at the current address whenever ready=1, and is 0 otherwise.
- A store commits at the rising edge where dmem_valid & dmem_ready & dmem_write & in-range. Bytes are written per dmem_wstrb.
- Same-cycle imem read and dmem write to the same word: imem returns the pre-write data. The new data is visible from the next cycle.
- Ports are fully independent; there is no arbitration.

## Timing
- Reset values:
  - FSMs in IDLE, cnt=0
  - imem_ready=0, dmem_ready=0, imem_err=0, dmem_err=0
  - imem_rdata=0, dmem_rdata=0
- While reset=1, all ready/err outputs are forced 0 and no store commits, including with LATENCY=0.
- Latency, with no stall, from the first cycle valid is seen high:
  - ready in cycle L (cycle 0 when L=0)
  - back-to-back requests with L=0 complete every cycle
  - with L>0, one request completes every L+1 cycles
- Each stall cycle while in WAIT adds exactly one cycle of latency. A stall in IDLE with L=0 moves the port to WAIT with cnt=0.
- Reset asserted mid-WAIT: at the next edge the FSM returns to IDLE and the pending request is discarded. The requester must re-issue it.
- Ready is a single-cycle pulse per request. The err output never asserts without its ready.

## Test plan
- L=0, no stall; store 0xDEADBEEF with wstrb=4'hF to 0x10, then load 0x10 -> dmem_ready in the same cycle as each request; load returns 0xDEADBEEF.
- DMEM_LATENCY=3; load request at cycle 0 -> dmem_ready only in cycle 3. Next request issued in cycle 4 -> its ready in cycle 7.
- ENABLE_STALL=1, IMEM_LATENCY=2, imem_stall high for 2 cycles mid-WAIT -> imem_ready in cycle 4, not cycle 2.
- MEM_WORDS=1024, BASE_ADDR=0; store to 0x1000 -> dmem_err=1 with ready and the memory is unchanged; load from 0x1000 -> rdata=0, err=1.
- wstrb=4'b0010, wdata=0x0000AB00 over an existing 0x11223344 -> read-back 0x1122AB44. Same-cycle imem fetch of that word returns 0x11223344.
- reset asserted in cycle 1 of a DMEM_LATENCY=3 request -> no ready in any cycle, store not committed, FSM in IDLE after reset.

Source files
------------

// File: rtl/kcore_formal_mem_if.sv
// Bus bundle between kcore's imem/dmem request side (master) and the memory model (slave).
// Handshake: a request is presented by raising *_valid with stable address/data and holding
// it until *_ready; one cycle with valid & ready completes exactly one transfer.
interface kcore_formal_mem_if;
  logic        imem_valid;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ready;
  logic        imem_stall;
  logic        imem_err;

  logic        dmem_valid;
  logic        dmem_write;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_wstrb;
  logic [31:0] dmem_rdata;
  logic        dmem_ready;
  logic        dmem_stall;
  logic        dmem_err;

  modport master (
    output imem_valid, imem_addr, imem_stall,
    output dmem_valid, dmem_write, dmem_addr, dmem_wdata, dmem_wstrb, dmem_stall,
    input  imem_rdata, imem_ready, imem_err,
    input  dmem_rdata, dmem_ready, dmem_err
  );

  modport slave (
    input  imem_valid, imem_addr, imem_stall,
    input  dmem_valid, dmem_write, dmem_addr, dmem_wdata, dmem_wstrb, dmem_stall,
    output imem_rdata, imem_ready, imem_err,
    output dmem_rdata, dmem_ready, dmem_err
  );
endinterface

// File: rtl/kcore_formal_mem.sv
// Word-addressed memory with independent fetch and data ports, each with a programmable
// response latency, optional stall input and out-of-range flagging.

module kcore_formal_mem_port #(
  parameter int unsigned LATENCY      = 0,
  parameter bit          ENABLE_STALL = 1'b0
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       valid,
  input  logic       stall,
  output logic       ready,
  output logic       dbg_wait,
  output logic [3:0] dbg_cnt
);
  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  // With LATENCY=0 a port only reaches WAIT through a stall; it then answers on the
  // first stall-free cycle, so the terminal count saturates at zero.
  localparam logic [3:0] LAST_CNT = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       stall_eff;

  assign stall_eff = ENABLE_STALL && stall;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ready   = 1'b0;
    case (state_q)
      IDLE: begin
        if (valid) begin
          if (LATENCY == 0 && !stall_eff) begin
            ready = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = 4'd0;
          end
        end
      end
      WAIT: begin
        if (!valid) begin
          // Requester abandoned the request; discard it silently.
          state_d = IDLE;
          cnt_d   = 4'd0;
        end else if (!stall_eff) begin
          if (cnt_q == LAST_CNT) begin
            ready   = 1'b1;
            state_d = IDLE;
            cnt_d   = 4'd0;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end
    endcase
    if (reset) begin
      ready = 1'b0;
    end
  end

  assign dbg_wait = (state_q == WAIT);
  assign dbg_cnt  = cnt_q;

  a_no_ready_in_reset: assert property (@(posedge clock) reset |-> !ready);
endmodule

module kcore_formal_mem #(
  parameter int unsigned MEM_WORDS    = 1024,
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
  parameter int unsigned IMEM_LATENCY = 0,
  parameter int unsigned DMEM_LATENCY = 0,
  parameter bit          ENABLE_STALL = 1'b0
) (
  input  logic                  clock,
  input  logic                  reset,
  kcore_formal_mem_if.slave     bus,
  output logic                  imem_dbg_wait,
  output logic [3:0]            imem_dbg_cnt,
  output logic                  dmem_dbg_wait,
  output logic [3:0]            dmem_dbg_cnt
);
  localparam int          AW        = $clog2(MEM_WORDS);
  localparam logic [32:0] MEM_BYTES = 33'(MEM_WORDS) << 2;

  if (MEM_WORDS < 4 || (MEM_WORDS & (MEM_WORDS - 1)) != 0) begin : g_bad_words
    $error("MEM_WORDS must be a power of two and at least 4");
  end
  if (IMEM_LATENCY > 15 || DMEM_LATENCY > 15) begin : g_bad_latency
    $error("port latencies are limited to 0..15");
  end

  logic [31:0] mem [MEM_WORDS];

  function automatic logic addr_in_range(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE_ADDR;
    return (a >= BASE_ADDR) && ({1'b0, off} < MEM_BYTES);
  endfunction

  function automatic logic [AW-1:0] word_index(input logic [31:0] a);
    return AW'((a - BASE_ADDR) >> 2);
  endfunction

  logic          i_ready, d_ready;
  logic          i_in_range, d_in_range;
  logic [AW-1:0] i_idx, d_idx;

  assign i_in_range = addr_in_range(bus.imem_addr);
  assign d_in_range = addr_in_range(bus.dmem_addr);
  assign i_idx      = word_index(bus.imem_addr);
  assign d_idx      = word_index(bus.dmem_addr);

  kcore_formal_mem_port #(
    .LATENCY      (IMEM_LATENCY),
    .ENABLE_STALL (ENABLE_STALL)
  ) u_imem_port (
    .clock    (clock),
    .reset    (reset),
    .valid    (bus.imem_valid),
    .stall    (bus.imem_stall),
    .ready    (i_ready),
    .dbg_wait (imem_dbg_wait),
    .dbg_cnt  (imem_dbg_cnt)
  );

  kcore_formal_mem_port #(
    .LATENCY      (DMEM_LATENCY),
    .ENABLE_STALL (ENABLE_STALL)
  ) u_dmem_port (
    .clock    (clock),
    .reset    (reset),
    .valid    (bus.dmem_valid),
    .stall    (bus.dmem_stall),
    .ready    (d_ready),
    .dbg_wait (dmem_dbg_wait),
    .dbg_cnt  (dmem_dbg_cnt)
  );

  // Reads are combinational from the array, so a fetch in the same cycle as a store
  // to the same word sees the pre-store contents.
  assign bus.imem_ready = i_ready;
  assign bus.imem_err   = i_ready & ~i_in_range;
  assign bus.imem_rdata = (i_ready && i_in_range) ? mem[i_idx] : 32'd0;

  assign bus.dmem_ready = d_ready;
  assign bus.dmem_err   = d_ready & ~d_in_range;
  assign bus.dmem_rdata = (d_ready && d_in_range) ? mem[d_idx] : 32'd0;

  // The array is deliberately left out of reset; d_ready is already gated by reset.
  always_ff @(posedge clock) begin
    if (d_ready && bus.dmem_write && d_in_range) begin
      for (int b = 0; b < 4; b++) begin
        if (bus.dmem_wstrb[b]) begin
          mem[d_idx][8*b +: 8] <= bus.dmem_wdata[8*b +: 8];
        end
      end
    end
  end

  a_imem_err_with_ready: assert property (@(posedge clock) bus.imem_err |-> bus.imem_ready);
  a_dmem_err_with_ready: assert property (@(posedge clock) bus.dmem_err |-> bus.dmem_ready);
endmodule

// File: tb/tb_kcore_formal_mem.sv
// Scoreboard bench for kcore_formal_mem: two instances (zero latency; latency 2/3 with
// stall enabled) share one clock; expected responses are queued per port and checked on ready.
module tb_kcore_formal_mem;
  logic clock = 1'b0;
  logic rst_a, rst_b;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  // Entry: [51:50] port, [49] check data, [48] err, [47:16] rdata, [15:0] ready cycle.
  // Ports: 0 = A imem, 1 = A dmem, 2 = B imem, 3 = B dmem.
  logic [51:0] exp_q[$];

  logic       a_iw, a_dw, b_iw, b_dw;
  logic [3:0] a_ic, a_dc, b_ic, b_dc;

  kcore_formal_mem_if ia();
  kcore_formal_mem_if ib();

  kcore_formal_mem #(
    .MEM_WORDS(1024), .BASE_ADDR(32'h0), .IMEM_LATENCY(0), .DMEM_LATENCY(0), .ENABLE_STALL(1'b0)
  ) dut_a (
    .clock(clock), .reset(rst_a), .bus(ia),
    .imem_dbg_wait(a_iw), .imem_dbg_cnt(a_ic), .dmem_dbg_wait(a_dw), .dmem_dbg_cnt(a_dc)
  );

  kcore_formal_mem #(
    .MEM_WORDS(1024), .BASE_ADDR(32'h0), .IMEM_LATENCY(2), .DMEM_LATENCY(3), .ENABLE_STALL(1'b1)
  ) dut_b (
    .clock(clock), .reset(rst_b), .bus(ib),
    .imem_dbg_wait(b_iw), .imem_dbg_cnt(b_ic), .dmem_dbg_wait(b_dw), .dmem_dbg_cnt(b_dc)
  );

  // Clock and cycle counter
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic logic p_ready(input int p);
    case (p)
      0: return ia.imem_ready;
      1: return ia.dmem_ready;
      2: return ib.imem_ready;
      default: return ib.dmem_ready;
    endcase
  endfunction

  function automatic logic p_err(input int p);
    case (p)
      0: return ia.imem_err;
      1: return ia.dmem_err;
      2: return ib.imem_err;
      default: return ib.dmem_err;
    endcase
  endfunction

  function automatic logic [31:0] p_rdata(input int p);
    case (p)
      0: return ia.imem_rdata;
      1: return ia.dmem_rdata;
      2: return ib.imem_rdata;
      default: return ib.dmem_rdata;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Driver tasks
  task automatic drive(input int p, input logic v, input logic wr, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] wstrb);
    case (p)
      0: begin ia.imem_valid = v; ia.imem_addr = addr; end
      1: begin
        ia.dmem_valid = v; ia.dmem_write = wr; ia.dmem_addr = addr;
        ia.dmem_wdata = wdata; ia.dmem_wstrb = wstrb;
      end
      2: begin ib.imem_valid = v; ib.imem_addr = addr; end
      default: begin
        ib.dmem_valid = v; ib.dmem_write = wr; ib.dmem_addr = addr;
        ib.dmem_wdata = wdata; ib.dmem_wstrb = wstrb;
      end
    endcase
  endtask

  task automatic set_stall(input int p, input logic v);
    case (p)
      0: ia.imem_stall = v;
      1: ia.dmem_stall = v;
      2: ib.imem_stall = v;
      default: ib.dmem_stall = v;
    endcase
  endtask

  // Called just after a rising edge; returns just after the rising edge that follows ready.
  task automatic req(input int p, input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [3:0] wstrb, input logic chk, input logic [31:0] exp_data,
                     input logic exp_err, input int lat, input int nstall, input string name);
    logic got;
    got = 1'b0;
    drive(p, 1'b1, wr, addr, wdata, wstrb);
    exp_q.push_back({2'(p), chk, exp_err, exp_data, 16'(cyc + lat)});
    if (nstall > 0) begin
      @(posedge clock); #1 set_stall(p, 1'b1);
      repeat (nstall - 1) @(posedge clock);
      @(posedge clock); #1 set_stall(p, 1'b0);
    end
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge clock);
      if (p_ready(p) === 1'b1) got = 1'b1;
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got no ready expected ready within 40 cycles", name);
    end
    @(posedge clock); #1 drive(p, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
  endtask

  // Monitor / scoreboard
  always @(negedge clock) begin : monitor
    logic [51:0] e;
    int          idx;
    for (int p = 0; p < 4; p++) begin
      if (p_ready(p) === 1'b1) begin
        idx = -1;
        for (int i = 0; i < exp_q.size(); i++) begin
          if (idx < 0 && exp_q[i][51:50] == 2'(p)) idx = i;
        end
        if (idx < 0) begin
          checks++;
          errors++;
          $display("FAIL p%0d_unexpected_ready: got ready in cycle %0d expected none", p, cyc);
        end else begin
          e = exp_q[idx];
          exp_q.delete(idx);
          check($sformatf("p%0d_ready_cycle", p), 32'(cyc), {16'h0, e[15:0]});
          check($sformatf("p%0d_err", p), {31'h0, p_err(p)}, {31'h0, e[48]});
          if (e[49]) check($sformatf("p%0d_rdata", p), p_rdata(p), e[47:16]);
        end
      end else if (p_err(p) !== 1'b0 || p_rdata(p) !== 32'h0) begin
        checks++;
        errors++;
        $display("FAIL p%0d_idle_outputs: got err=%b rdata=%h expected err=0 rdata=0",
                 p, p_err(p), p_rdata(p));
      end
    end
  end

  initial begin
    rst_a = 1'b1;
    rst_b = 1'b1;
    for (int p = 0; p < 4; p++) begin
      drive(p, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      set_stall(p, 1'b0);
    end
    repeat (2) @(posedge clock);
    #1;
    // Requests held during reset must not be answered, even with zero latency.
    drive(0, 1'b1, 1'b0, 32'h10, 32'h0, 4'h0);
    drive(1, 1'b1, 1'b1, 32'h10, 32'hFFFF_FFFF, 4'hF);
    drive(2, 1'b1, 1'b0, 32'h10, 32'h0, 4'h0);
    drive(3, 1'b1, 1'b1, 32'h10, 32'hFFFF_FFFF, 4'hF);
    @(negedge clock);
    for (int p = 0; p < 4; p++) begin
      check($sformatf("rst_p%0d_ready", p), {31'h0, p_ready(p)}, 32'h0);
      check($sformatf("rst_p%0d_err", p), {31'h0, p_err(p)}, 32'h0);
      check($sformatf("rst_p%0d_rdata", p), p_rdata(p), 32'h0);
    end
    check("rst_b_dmem_wait", {31'h0, b_dw}, 32'h0);
    @(posedge clock); #1;
    for (int p = 0; p < 4; p++) drive(p, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    rst_a = 1'b0;
    rst_b = 1'b0;

    // Instance A, zero latency: store then load.
    req(1, 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 1'b0, 32'h0, 1'b0, 0, 0, "a_st10");
    req(1, 1'b0, 32'h10, 32'h0, 4'h0, 1'b1, 32'hDEAD_BEEF, 1'b0, 0, 0, "a_ld10");
    req(1, 1'b1, 32'h20, 32'h1122_3344, 4'hF, 1'b0, 32'h0, 1'b0, 0, 0, "a_st20");
    req(1, 1'b0, 32'h22, 32'h0, 4'h0, 1'b1, 32'h1122_3344, 1'b0, 0, 0, "a_ld22");

    // Partial store with a same-cycle fetch of the same word.
    fork
      req(1, 1'b1, 32'h20, 32'h0000_AB00, 4'b0010, 1'b1, 32'h1122_3344, 1'b0, 0, 0, "a_stb");
      req(0, 1'b0, 32'h20, 32'h0, 4'h0, 1'b1, 32'h1122_3344, 1'b0, 0, 0, "a_if_same");
    join
    req(1, 1'b0, 32'h20, 32'h0, 4'h0, 1'b1, 32'h1122_AB44, 1'b0, 0, 0, "a_ld20");
    req(0, 1'b0, 32'h20, 32'h0, 4'h0, 1'b1, 32'h1122_AB44, 1'b0, 0, 0, "a_if20");

    // Range boundaries.
    req(1, 1'b1, 32'h0, 32'hCAFE_F00D, 4'hF, 1'b0, 32'h0, 1'b0, 0, 0, "a_st0");
    req(1, 1'b1, 32'h1000, 32'hFFFF_FFFF, 4'hF, 1'b1, 32'h0, 1'b1, 0, 0, "a_st_oor");
    req(1, 1'b0, 32'h1000, 32'h0, 4'h0, 1'b1, 32'h0, 1'b1, 0, 0, "a_ld_oor");
    req(1, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'hCAFE_F00D, 1'b0, 0, 0, "a_ld0");
    req(0, 1'b0, 32'hFFFF_FFFC, 32'h0, 4'h0, 1'b1, 32'h0, 1'b1, 0, 0, "a_if_oor");
    req(1, 1'b1, 32'hFFC, 32'h0BAD_F00D, 4'hF, 1'b0, 32'h0, 1'b0, 0, 0, "a_st_top");
    req(1, 1'b0, 32'hFFC, 32'h0, 4'h0, 1'b1, 32'h0BAD_F00D, 1'b0, 0, 0, "a_ld_top");
    req(0, 1'b0, 32'h12, 32'h0, 4'h0, 1'b1, 32'hDEAD_BEEF, 1'b0, 0, 0, "a_if12");

    // Instance B: data latency 3, back-to-back requests.
    req(3, 1'b1, 32'h40, 32'h55AA_55AA, 4'hF, 1'b0, 32'h0, 1'b0, 3, 0, "b_st40");
    req(3, 1'b0, 32'h40, 32'h0, 4'h0, 1'b1, 32'h55AA_55AA, 1'b0, 3, 0, "b_ld40");
    req(3, 1'b0, 32'h2000, 32'h0, 4'h0, 1'b1, 32'h0, 1'b1, 3, 0, "b_ld_oor");

    // Fetch latency 2, plain and with two stall cycles mid-wait.
    req(2, 1'b0, 32'h40, 32'h0, 4'h0, 1'b1, 32'h55AA_55AA, 1'b0, 2, 0, "b_if40");
    req(2, 1'b0, 32'h40, 32'h0, 4'h0, 1'b1, 32'h55AA_55AA, 1'b0, 4, 2, "b_if40_stall");

    // Reset in cycle 1 of a latency-3 store discards it.
    drive(3, 1'b1, 1'b1, 32'h40, 32'h1234_5678, 4'hF);
    @(posedge clock); #1 rst_b = 1'b1;
    @(posedge clock); #1 drive(3, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    @(negedge clock);
    check("b_rst_dmem_wait", {31'h0, b_dw}, 32'h0);
    check("b_rst_dmem_cnt", {28'h0, b_dc}, 32'h0);
    @(posedge clock); #1 rst_b = 1'b0;
    req(3, 1'b0, 32'h40, 32'h0, 4'h0, 1'b1, 32'h55AA_55AA, 1'b0, 3, 0, "b_ld40_after_rst");

    repeat (3) @(posedge clock);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL pending_responses: got %0d outstanding expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
